// File: rtl/counter_seq_ctrl_pkg.sv
// counter_seq_ctrl_pkg: shared state encodings and default width for the counter sequencer.
package counter_seq_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10
  } state_t;
  localparam int CNT_WIDTH_DEF = 4;
endpackage

// File: rtl/counter_seq_ctrl_if.sv
// counter_seq_ctrl_if: host-side start/stop handshake and status; COUNT_SEQ_PAUSE_EN adds pause.
interface counter_seq_ctrl_if #(
  parameter int WIDTH = 4
);
  logic start, stop, periodic, busy, done;
  logic [WIDTH-1:0] limit, count;
`ifdef COUNT_SEQ_PAUSE_EN
  logic pause;
  modport master(output start, stop, periodic, limit, pause, input busy, done, count);
  modport slave(input start, stop, periodic, limit, pause, output busy, done, count);
`else
  modport master(output start, stop, periodic, limit, input busy, done, count);
  modport slave(input start, stop, periodic, limit, output busy, done, count);
`endif
endinterface

// File: rtl/counter_seq_ctrl_core.sv
// counter_core: ffd-based WIDTH-bit counter with synchronous clear and enable.
module ffd (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= 1'b0;
    else q <= d;
endmodule

module counter_core
  import counter_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] d;
  assign d = clr ? '0 : en ? q + 1'b1 : q;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ffd u_ffd (.clk, .rst, .d(d[i]), .q(q[i]));
  end
endmodule

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: interval-timer sequencer owning counter en/clr; COUNT_SEQ_PAUSE_EN adds pause/PAUSED.
module counter_seq_ctrl
  import counter_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEF
) (
  input logic               clk,
  input logic               rst,
  counter_seq_ctrl_if.slave bus
);
  state_t state, state_next;
  logic [WIDTH-1:0] limit_q, q;
  logic periodic_q, en, clr, load, done_next, hold, busy, done;
`ifdef COUNT_SEQ_PAUSE_EN
  assign hold = bus.pause;
`else
  assign hold = 1'b0;
`endif
  counter_core #(.WIDTH(WIDTH)) core (.clk, .rst, .en, .clr, .q);
  // stop beats pause, pause beats terminal; PAUSED with pause low steps exactly like RUN
  always_comb begin
    state_next = state;
    en = 1'b0;
    clr = 1'b0;
    load = 1'b0;
    done_next = 1'b0;
    case (state)
      ST_IDLE: begin
        clr = 1'b1;
        if (bus.start && !bus.stop) begin
          state_next = ST_RUN;
          load = 1'b1;
        end
      end
      default: begin
        if (bus.stop) begin
          state_next = ST_IDLE;
          clr = 1'b1;
        end else if (hold) begin
          state_next = ST_PAUSED;
        end else if (q == limit_q) begin
          state_next = periodic_q ? ST_RUN : ST_IDLE;
          clr = 1'b1;
          done_next = 1'b1;
        end else begin
          state_next = ST_RUN;
          en = 1'b1;
        end
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      limit_q <= '0;
      periodic_q <= 1'b0;
    end else begin
      state <= state_next;
      busy <= state_next != ST_IDLE;
      done <= done_next;
      if (load) begin
        limit_q <= bus.limit;
        periodic_q <= bus.periodic;
      end
    end
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.count = q;
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: directed vectors checked against a cycle model and literal expectations.
module tb_counter_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic pause_in;
  int tests = 0;
  int fails = 0;
  int m_cnt = 0, m_lim = 0;
  bit m_act = 0, m_per = 0, m_done = 0;
  always #5 clk = ~clk;
  counter_seq_ctrl_if #(.WIDTH(4)) bus ();
  counter_seq_ctrl #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
`ifdef COUNT_SEQ_PAUSE_EN
  assign pause_in = bus.pause;
`else
  assign pause_in = 1'b0;
`endif
  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask
  task automatic step(int n = 1);
    repeat (n) @(negedge clk);
  endtask
  // reference timer: a run is limit+1 cycles long, done follows the terminal cycle
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 0; m_cnt = 0; m_done = 0; m_lim = 0; m_per = 0;
    end else begin
      m_done = 0;
      if (!m_act) begin
        if (bus.start && !bus.stop) begin
          m_act = 1; m_lim = int'(bus.limit); m_per = bus.periodic;
        end
      end else if (bus.stop) begin
        m_act = 0; m_cnt = 0;
      end else if (!pause_in) begin
        if (m_cnt == m_lim) begin
          m_done = 1; m_cnt = 0; m_act = m_per;
        end else m_cnt = m_cnt + 1;
      end
    end
  end
  always @(negedge clk)
    if (run) begin
      chk("model_busy", int'(bus.busy), int'(m_act));
      chk("model_done", int'(bus.done), int'(m_done));
      chk("model_count", int'(bus.count), m_cnt);
    end
  initial begin
    bus.start = 0; bus.stop = 0; bus.periodic = 0; bus.limit = 0;
`ifdef COUNT_SEQ_PAUSE_EN
    bus.pause = 0;
`endif
    step(2);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_count", int'(bus.count), 0);
    chk("reset_done", int'(bus.done), 0);
    rst = 0;
    run = 1;
    step();
    // one-shot, limit 5
    bus.start = 1; bus.limit = 5; bus.periodic = 0;
    step();
    bus.start = 0;
    chk("os_first_count", int'(bus.count), 0);
    chk("os_first_busy", int'(bus.busy), 1);
    step(5);
    chk("os_last_count", int'(bus.count), 5);
    step();
    chk("os_done", int'(bus.done), 1);
    chk("os_done_busy", int'(bus.busy), 0);
    chk("os_done_count", int'(bus.count), 0);
    step();
    chk("os_done_once", int'(bus.done), 0);
    step(2);
    // periodic, limit 2, limit changed mid-run
    bus.start = 1; bus.limit = 2; bus.periodic = 1;
    step();
    bus.start = 0;
    step(2);
    chk("per_count2", int'(bus.count), 2);
    step();
    chk("per_done1", int'(bus.done), 1);
    chk("per_busy", int'(bus.busy), 1);
    bus.limit = 7;
    step(3);
    chk("per_done2", int'(bus.done), 1);
    chk("per_wrap", int'(bus.count), 0);
    bus.stop = 1;
    step();
    bus.stop = 0;
    chk("per_stopped", int'(bus.busy), 0);
    // stop coinciding with terminal, then start+stop in idle
    bus.start = 1; bus.limit = 4; bus.periodic = 0;
    step();
    bus.start = 0;
    step(4);
    chk("term_count", int'(bus.count), 4);
    bus.stop = 1;
    step();
    chk("stop_term_done", int'(bus.done), 0);
    chk("stop_term_busy", int'(bus.busy), 0);
    bus.start = 1;
    step();
    chk("start_stop_idle", int'(bus.busy), 0);
    bus.start = 0; bus.stop = 0;
    // full-range limit with start held through the run
    bus.start = 1; bus.limit = 15; bus.periodic = 0;
    step(16);
    chk("full_count15", int'(bus.count), 15);
    chk("full_busy", int'(bus.busy), 1);
    step();
    chk("full_done", int'(bus.done), 1);
    chk("full_clear", int'(bus.count), 0);
    step();
    chk("full_restart", int'(bus.busy), 1);
    chk("full_restart_done", int'(bus.done), 0);
    bus.start = 0; bus.stop = 1;
    step();
    bus.stop = 0;
    // asynchronous reset mid-run at count 3
    bus.start = 1; bus.limit = 9;
    step();
    bus.start = 0;
    step(3);
    chk("pre_reset_count", int'(bus.count), 3);
    #2 rst = 1;
    #1;
    chk("async_rst_count", int'(bus.count), 0);
    chk("async_rst_busy", int'(bus.busy), 0);
    chk("async_rst_done", int'(bus.done), 0);
    step();
    rst = 0;
    bus.start = 1; bus.limit = 1;
    step();
    bus.start = 0;
    chk("post_rst_busy", int'(bus.busy), 1);
    step(2);
    chk("post_rst_done", int'(bus.done), 1);
`ifdef COUNT_SEQ_PAUSE_EN
    step();
    bus.start = 1; bus.limit = 5; bus.periodic = 0;
    step();
    bus.start = 0;
    step(2);
    bus.pause = 1;
    step(4);
    chk("pause_hold", int'(bus.count), 2);
    chk("pause_busy", int'(bus.busy), 1);
    bus.pause = 0;
    step();
    chk("pause_resume", int'(bus.count), 3);
    step(2);
    chk("pause_count5", int'(bus.count), 5);
    step();
    chk("pause_done", int'(bus.done), 1);
`endif
    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
